// File: rtl/picorv32_alu_pkg.sv
// -----------------------------------------------------------------------------
// picorv32_alu_pkg
//   Shared definitions for the sequential picorv32 ALU:
//     - ALU_OP_W and the encoded opcodes ALU_ADD .. ALU_SLTU
//     - shifter mode encoding (left / logical right / arithmetic right)
//     - FSM state encoding for the top-level controller
//   Optional feature macro: PICORV32_ALU_CMP_EN (SLT/SLTU). The package is
//   the same whether or not it is defined; only the top-level decoder changes.
// -----------------------------------------------------------------------------
package picorv32_alu_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

   localparam int SH_MODE_W = 2;

   localparam logic [SH_MODE_W-1:0] SH_LEFT = 2'd0;
   localparam logic [SH_MODE_W-1:0] SH_SRL  = 2'd1;
   localparam logic [SH_MODE_W-1:0] SH_SRA  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/picorv32_alu_shifter.sv
// -----------------------------------------------------------------------------
// picorv32_alu_shifter
//   Iterative shifter: moves the operand by at most SHIFT_STEP bits per cycle
//   until the requested amount has been consumed.
//
//   Ports
//     clk, rst   clock / asynchronous active-high reset
//     start      load data_in, amount and mode (amount must be non-zero)
//     mode       SH_LEFT, SH_SRL or SH_SRA
//     data_in    value to shift
//     amount     total shift distance, 0 .. XLEN-1
//     done       high in the cycle whose step finishes the shift; result is
//                the final value in that cycle (the caller registers it)
//     result     the value after the current cycle's step
//
//   Parameters: XLEN (datapath width), SHIFT_STEP (max bits per cycle).
// -----------------------------------------------------------------------------
module picorv32_alu_shifter
   import picorv32_alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [SH_MODE_W-1:0]      mode,
   input  logic [XLEN-1:0]           data_in,
   input  logic [$clog2(XLEN)-1:0]   amount,
   output logic                      done,
   output logic [XLEN-1:0]           result
);

   // One extra bit so SHIFT_STEP == XLEN still fits in the counter width.
   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

   logic                 busy_q;
   logic [XLEN-1:0]      data_q;
   logic [CNT_W-1:0]     remaining_q;
   logic [SH_MODE_W-1:0] mode_q;
   logic [CNT_W-1:0]     step_amt;

   always_comb begin
      step_amt = (remaining_q > STEP_C) ? STEP_C : remaining_q;
      case (mode_q)
         SH_LEFT: result = data_q << step_amt;
         SH_SRA:  result = $unsigned($signed(data_q) >>> step_amt);
         default: result = data_q >> step_amt;
      endcase
   end

   // The final step is the one that consumes everything that is left.
   assign done = busy_q && (remaining_q <= STEP_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q      <= 1'b0;
         data_q      <= '0;
         remaining_q <= '0;
         mode_q      <= SH_SRL;
      end else if (start) begin
         busy_q      <= 1'b1;
         data_q      <= data_in;
         remaining_q <= {1'b0, amount};
         mode_q      <= mode;
      end else if (busy_q) begin
         data_q      <= result;
         remaining_q <= remaining_q - step_amt;
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/picorv32_alu_seq.sv
// -----------------------------------------------------------------------------
// picorv32_alu_seq
//   Multi-cycle ALU for the picorv32 execute stage. Add/sub/logic/compare
//   complete in one cycle; shifts run on picorv32_alu_shifter.
//
//   Ports
//     clk, rst     clock / asynchronous active-high reset
//     in_valid     operation offered            in_ready  operation accepted
//     in_op        encoded opcode (see picorv32_alu_pkg)
//     in_op1/2     operands; shifts use in_op2[$clog2(XLEN)-1:0]
//     out_valid    result available             out_ready result consumed
//     out_result   result                       out_err   illegal opcode
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   in_* are only sampled on that edge. out_valid, once high, stays high with
//   out_result/out_err stable until out_ready is seen (only rst drops it).
//   In DONE, in_ready follows out_ready so a new op can be accepted in the
//   same cycle the previous result is consumed.
//
//   Optional feature: define PICORV32_ALU_CMP_EN to build SLT/SLTU; otherwise
//   opcodes 8 and 9 report out_err like any other illegal opcode.
// -----------------------------------------------------------------------------
module picorv32_alu_seq
   import picorv32_alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_op,
   input  logic [XLEN-1:0]     in_op1,
   input  logic [XLEN-1:0]     in_op2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_result,
   output logic                out_err
);

   localparam int SH_W = $clog2(XLEN);

   alu_state_t           state, state_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic                 err_q, err_d;

   logic                 accept;
   logic [SH_W-1:0]      shamt;
   logic [XLEN-1:0]      acc_result;
   logic                 acc_err;
   logic                 acc_shift;
   logic [SH_MODE_W-1:0] sh_mode;
   logic                 sh_start;
   logic                 sh_done;
   logic [XLEN-1:0]      sh_result;

   assign shamt     = in_op2[SH_W-1:0];
   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign out_result = result_q;
   assign out_err    = err_q;

   // Single-cycle datapath and decode of the offered op. For a shift by
   // zero the answer is op1 itself, so it completes without the shifter.
   always_comb begin
      acc_result = '0;
      acc_err    = 1'b0;
      acc_shift  = 1'b0;
      sh_mode    = SH_SRL;
      case (in_op)
         ALU_ADD: acc_result = in_op1 + in_op2;
         ALU_SUB: acc_result = in_op1 - in_op2;
         ALU_AND: acc_result = in_op1 & in_op2;
         ALU_OR:  acc_result = in_op1 | in_op2;
         ALU_XOR: acc_result = in_op1 ^ in_op2;
         ALU_SLL: begin
            sh_mode    = SH_LEFT;
            acc_shift  = (shamt != '0);
            acc_result = in_op1;
         end
         ALU_SRL: begin
            sh_mode    = SH_SRL;
            acc_shift  = (shamt != '0);
            acc_result = in_op1;
         end
         ALU_SRA: begin
            sh_mode    = SH_SRA;
            acc_shift  = (shamt != '0);
            acc_result = in_op1;
         end
`ifdef PICORV32_ALU_CMP_EN
         ALU_SLT:  acc_result = {{(XLEN-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
         ALU_SLTU: acc_result = {{(XLEN-1){1'b0}}, (in_op1 < in_op2)};
`endif
         default: begin
            acc_result = '0;
            acc_err    = 1'b1;
         end
      endcase
   end

   // Next state and result register. An accept takes priority over the
   // DONE -> IDLE fall-back so the consume cycle can start a new op.
   always_comb begin
      state_d  = state;
      result_d = result_q;
      err_d    = err_q;
      sh_start = 1'b0;
      case (state)
         ST_IDLE: state_d = ST_IDLE;
         ST_EXEC: begin
            if (sh_done) begin
               state_d  = ST_DONE;
               result_d = sh_result;
               err_d    = 1'b0;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         sh_start = acc_shift;
         state_d  = acc_shift ? ST_EXEC : ST_DONE;
         result_d = acc_result;
         err_d    = acc_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   picorv32_alu_shifter #(
      .XLEN       (XLEN),
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (sh_start),
      .mode    (sh_mode),
      .data_in (in_op1),
      .amount  (shamt),
      .done    (sh_done),
      .result  (sh_result)
   );

endmodule
